axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 256, cycles a channel may stall before abort (only used with AXI_MASTER_TIMEOUT_EN).
REQ-002 SHALL have one clock; reset is asynchronous and active-low: ACLK in 1 clock; ARESETN in 1 active-low async reset.
REQ-003 SHALL have ports: req_valid in 1 CPU request valid; req_ready out 1 request accepted.
REQ-004 SHALL have ports: req_we in 1 1=write 0=read; req_addr in 32 byte address; req_wdata in 32 write data; req_wstrb in 4 byte mask.
REQ-005 SHALL have ports: resp_valid out 1 one-cycle completion pulse; resp_rdata out 32 read data; resp_err out 1 error flag.
REQ-006 SHALL have read-address ports: ARADDR out 32; ARVALID out 1; ARREADY in 1.
REQ-007 SHALL have read-data ports: RDATA in 32; RRESP in 2; RVALID in 1; RREADY out 1.
REQ-008 SHALL have write-address ports: AWADDR out 32; AWVALID out 1; AWREADY in 1.
REQ-009 SHALL have write-data ports: WDATA out 32; WSTRB out 4; WVALID out 1; WREADY in 1.
REQ-010 SHALL have write-response ports: BRESP in 2; BVALID in 1; BREADY out 1.

Function
REQ-011 SHALL implement FSM states IDLE, AR, R, WR, B, RESP; one outstanding transaction max.
REQ-012 SHALL drive req_ready=1 only in IDLE; on req_valid&req_ready, latch addr/wdata/wstrb/we and go to AR (read) or WR (write).
REQ-013 AR: ARVALID=1, ARADDR=latched addr, held stable until ARREADY sampled high; then R.
REQ-014 R: RREADY=1 until RVALID; on that edge capture RDATA, resp_err=RRESP[1]; go RESP.
REQ-015 WR: AWVALID and WVALID assert together; each drops independently after its own handshake; go B once both done, same-cycle completion included.
REQ-016 B: BREADY=1 until BVALID; resp_err=BRESP[1]; go RESP.
REQ-017 RESP: resp_valid=1 for exactly one cycle; resp_rdata=captured data for reads, 0 for writes; next state IDLE.
REQ-018 Minimum read latency: request accepted cycle 0, ARVALID cycle 1, RVALID at cycle 2 gives resp_valid at cycle 3; writes have the same latency.
REQ-019 SHALL never deassert any VALID before its handshake; payload stable while VALID=1; wstrb=0 write still issued.

Reset
REQ-020 While ARESETN=0: state IDLE, all outputs 0 (req_ready included), captured data and error cleared; assertion takes effect immediately and asynchronously.
REQ-021 Reset mid-transaction SHALL abort silently with no resp_valid; req_ready=1 on the first ACLK edge after release.

Configuration
REQ-022 With AXI_MASTER_TIMEOUT_EN defined: a cycle counter runs in AR/R/WR/B and clears on every state entry; on reaching TIMEOUT_CYCLES-1, drop all VALID/READY and go RESP with resp_err=1, resp_rdata=0.
REQ-023 Without AXI_MASTER_TIMEOUT_EN: no counter exists; the FSM waits indefinitely; TIMEOUT_CYCLES is ignored.

Verification
REQ-024 Read addr 0x1000, slave ARREADY immediate, RVALID next cycle, RDATA 0xDEADBEEF, RRESP 00 -> resp_valid cycle 3, resp_rdata 0xDEADBEEF, resp_err 0.
REQ-025 Write 0x2000 data 0x12345678 strb 0xF, AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops first, AWVALID held until cycle 4, single B handshake, resp_err 0.
REQ-026 Write with BRESP=10 -> resp_err 1, resp_rdata 0, exactly one resp_valid pulse.
REQ-027 ARESETN low while in R -> RREADY=0 immediately, no resp_valid; after release req_ready=1 and the next read completes normally.
REQ-028 With AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, ARREADY stuck 0 -> ARVALID drops after 16 cycles, resp_valid with resp_err 1; without the macro ARVALID stays 1 beyond 100 cycles.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master that turns a simple CPU request/response port into AR/R or AW/W/B traffic.
// Defining AXI_MASTER_TIMEOUT_EN adds a per-state stall counter that aborts a stuck transaction with an error.
module axi_lite_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RESP} state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;

  logic        w_aw_done;
  logic        w_w_done;
  logic        w_timeout;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axi_lite_master: TIMEOUT_CYCLES must be at least 2");
  end

  // A write channel counts as done once its VALID has already dropped or is being accepted now.
  assign w_aw_done = !r_awvalid || AWREADY;
  assign w_w_done  = !r_wvalid  || WREADY;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wait;
  logic             w_hs_leave;

  assign w_wait     = (r_state == S_AR) || (r_state == S_R) ||
                      (r_state == S_WR) || (r_state == S_B);
  assign w_hs_leave = ((r_state == S_AR) && ARREADY) ||
                      ((r_state == S_R)  && RVALID)  ||
                      ((r_state == S_WR) && w_aw_done && w_w_done) ||
                      ((r_state == S_B)  && BVALID);
  // A real handshake wins over an expiring counter on the same edge.
  assign w_timeout  = w_wait && !w_hs_leave && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts at zero on every state entry because it is cleared whenever a state is left.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cnt <= '0;
    end else if (w_wait && !w_hs_leave && !w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
    end else if (w_timeout) begin
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b1;
      r_resp_valid <= 1'b1;
      r_state      <= S_RESP;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            if (req_we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (RVALID) begin
            r_rready     <= 1'b0;
            r_resp_rdata <= RDATA;
            r_resp_err   <= RRESP[1];
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_WR: begin
          if (w_aw_done && w_w_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_B;
          end else begin
            if (AWREADY) r_awvalid <= 1'b0;
            if (WREADY)  r_wvalid  <= 1'b0;
          end
        end
        S_B: begin
          if (BVALID) begin
            r_bready     <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= BRESP[1];
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign ARADDR     = r_addr;
  assign ARVALID    = r_arvalid;
  assign RREADY     = r_rready;
  assign AWADDR     = r_addr;
  assign AWVALID    = r_awvalid;
  assign WDATA      = r_wdata;
  assign WSTRB      = r_wstrb;
  assign WVALID     = r_wvalid;
  assign BREADY     = r_bready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed testbench for axi_lite_master: table of read/write transactions against a delay-programmable slave,
// plus hand-written reset-abort and stall/timeout sequences.
module tb_axi_lite_master;

  logic        ACLK;
  logic        ARESETN;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  axi_lite_master #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          a_dly;   // cycles AR/AW VALID is held before READY
    int          w_dly;   // cycles WVALID is held before WREADY
    int          d_dly;   // extra cycles before RVALID/BVALID
    logic [31:0] sdata;
    logic [1:0]  sresp;
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  // Results of the last do_txn
  int          t_lat;
  int          t_nresp;
  logic [31:0] t_rdata;
  logic        t_err;
  int          t_viol;
  int          t_a_hs_n;
  int          t_d_hs_n;
  int          t_a_last;
  int          t_w_last;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_slave();
    ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    RVALID = 1'b0; RDATA = '0; RRESP = '0;
    BVALID = 1'b0; BRESP = '0;
  endtask

  // Entered at a negedge. Cycle 0 is the cycle in which the request is accepted.
  task automatic do_txn(input vec_t v);
    int c, acc_wait, a_first, a_hs, w_first, w_hs, d_start;
    bit d_done, a_valid, a_rdy, w_rdy, d_vld, d_rdy;
    logic [31:0] a_addr;
    t_lat = -1; t_nresp = 0; t_rdata = '0; t_err = 1'b0; t_viol = 0;
    t_a_hs_n = 0; t_d_hs_n = 0; t_a_last = -1; t_w_last = -1;
    a_first = -1; a_hs = -1; w_first = -1; w_hs = -1; d_done = 1'b0;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
    acc_wait = 0;
    while (!req_ready && acc_wait < 20) begin
      @(negedge ACLK);
      acc_wait++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    for (c = 1; c < 80; c++) begin
      @(negedge ACLK);
      if (c == 1) req_valid = 1'b0;
      a_valid = v.we ? AWVALID : ARVALID;
      a_addr  = v.we ? AWADDR : ARADDR;
      a_rdy   = 1'b0;
      if (a_valid) begin
        if (a_first < 0) a_first = c;
        if (a_addr !== v.addr) t_viol++;
        a_rdy = (c - a_first >= v.a_dly);
        if (a_rdy) begin a_hs = c; t_a_hs_n++; end
        t_a_last = c;
      end else if (a_first >= 0 && a_hs < 0) t_viol++;
      if (v.we) AWREADY = a_rdy; else ARREADY = a_rdy;
      w_rdy = 1'b0;
      if (v.we) begin
        if (WVALID) begin
          if (w_first < 0) w_first = c;
          if (WDATA !== v.wdata || WSTRB !== v.wstrb) t_viol++;
          w_rdy = (c - w_first >= v.w_dly);
          if (w_rdy) w_hs = c;
          t_w_last = c;
        end else if (w_first >= 0 && w_hs < 0) t_viol++;
      end
      WREADY = w_rdy;
      if (v.we) d_start = (a_hs >= 0 && w_hs >= 0) ? ((a_hs > w_hs ? a_hs : w_hs) + 1 + v.d_dly) : -1;
      else      d_start = (a_hs >= 0) ? (a_hs + 1 + v.d_dly) : -1;
      d_vld = (d_start >= 0) && (c >= d_start) && !d_done;
      d_rdy = v.we ? BREADY : RREADY;
      if (v.we) begin
        BVALID = d_vld; BRESP = v.sresp;
      end else begin
        RVALID = d_vld; RDATA = v.sdata; RRESP = v.sresp;
      end
      if (d_vld && d_rdy) begin d_done = 1'b1; t_d_hs_n++; end
      if (resp_valid) begin
        t_nresp++;
        if (t_lat < 0) begin t_lat = c; t_rdata = resp_rdata; t_err = resp_err; end
      end
      if (t_lat >= 0 && c >= t_lat + 2) break;
    end
    idle_slave();
  endtask

  int rv_n, av_n, resp_c;
  logic [31:0] g_rdata;
  logic        g_err;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"rd_basic",   1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 3, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{"rd_slow",    1'b0, 32'h0000_1004, 32'h0, 4'h0, 2, 0, 3, 32'h0BAD_F00D, 2'b10, 8, 32'h0BAD_F00D, 1'b1};
    vecs[2] = '{"rd_decerr",  1'b0, 32'h0000_1008, 32'h0, 4'h0, 1, 0, 0, 32'hA5A5_A5A5, 2'b11, 4, 32'hA5A5_A5A5, 1'b1};
    vecs[3] = '{"rd_exokay",  1'b0, 32'h0000_100C, 32'h0, 4'h0, 0, 0, 1, 32'h0000_0005, 2'b01, 4, 32'h0000_0005, 1'b0};
    vecs[4] = '{"wr_aw_late", 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 3, 0, 0, 32'h0, 2'b00, 6, 32'h0, 1'b0};
    vecs[5] = '{"wr_slverr",  1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'h3, 0, 0, 0, 32'h0, 2'b10, 3, 32'h0, 1'b1};
    vecs[6] = '{"wr_strb0",   1'b1, 32'h0000_3000, 32'hFFFF_FFFF, 4'h0, 0, 2, 1, 32'h0, 2'b00, 6, 32'h0, 1'b0};
    vecs[7] = '{"wr_same",    1'b1, 32'h0000_3004, 32'h0F0F_0F0F, 4'hA, 2, 2, 0, 32'h0, 2'b01, 5, 32'h0, 1'b0};

    ARESETN = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    idle_slave();
    repeat (2) @(negedge ACLK);

    // Reset state
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_valids", {26'b0, ARVALID, RREADY, AWVALID, WVALID, BREADY, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err_payload", {resp_err, 4'h0, WSTRB} | ARADDR | WDATA, 32'd0);
    ARESETN = 1'b1;
    #1 check("rel_req_ready_pre_edge", {31'b0, req_ready}, 32'd0);
    @(negedge ACLK);
    check("rel_req_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i]);
      check({vecs[i].name, "_lat"}, t_lat, vecs[i].exp_lat);
      check({vecs[i].name, "_nresp"}, t_nresp, 32'd1);
      check({vecs[i].name, "_rdata"}, t_rdata, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, {31'b0, t_err}, {31'b0, vecs[i].exp_err});
      check({vecs[i].name, "_proto"}, t_viol, 32'd0);
      check({vecs[i].name, "_addr_hs"}, t_a_hs_n, 32'd1);
      check({vecs[i].name, "_data_hs"}, t_d_hs_n, 32'd1);
      if (vecs[i].we) begin
        check({vecs[i].name, "_aw_last"}, t_a_last, 1 + vecs[i].a_dly);
        check({vecs[i].name, "_w_last"}, t_w_last, 1 + vecs[i].w_dly);
      end
    end

    // Reset asserted while waiting in R: outputs drop asynchronously, no response is produced
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4000;
    @(negedge ACLK);
    req_valid = 1'b0;
    check("rstR_arvalid", {31'b0, ARVALID}, 32'd1);
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
    check("rstR_in_R", {31'b0, RREADY}, 32'd1);
    #2 ARESETN = 1'b0;
    #1 check("rstR_rready_async", {29'b0, RREADY, ARVALID, req_ready}, 32'd0);
    rv_n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      if (resp_valid) rv_n++;
    end
    ARESETN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      if (resp_valid) rv_n++;
      if (k == 0) check("rstR_req_ready_after", {31'b0, req_ready}, 32'd1);
    end
    check("rstR_no_resp", rv_n, 32'd0);
    do_txn(vecs[0]);
    check("rstR_next_lat", t_lat, 32'd3);
    check("rstR_next_rdata", t_rdata, 32'hDEAD_BEEF);

    // ARREADY stuck low
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_5000;
    @(negedge ACLK);
    req_valid = 1'b0;
    av_n = 0; rv_n = 0; resp_c = -1; g_rdata = '1; g_err = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
    for (int c = 1; c <= 40; c++) begin
      if (ARVALID) av_n++;
      if (resp_valid) begin
        rv_n++;
        if (resp_c < 0) begin resp_c = c; g_rdata = resp_rdata; g_err = resp_err; end
      end
      @(negedge ACLK);
    end
    check("to_arvalid_cycles", av_n, 32'd16);
    check("to_resp_cycle", resp_c, 32'd17);
    check("to_nresp", rv_n, 32'd1);
    check("to_err", {31'b0, g_err}, 32'd1);
    check("to_rdata", g_rdata, 32'd0);
`else
    for (int c = 1; c <= 110; c++) begin
      if (ARVALID) av_n++;
      if (resp_valid) rv_n++;
      @(negedge ACLK);
    end
    check("stall_arvalid_cycles", av_n, 32'd110);
    check("stall_nresp", rv_n, 32'd0);
    ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
`endif
    do_txn(vecs[4]);
    check("final_wr_lat", t_lat, 32'd6);
    check("final_wr_err", {31'b0, t_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
